sr_load_scheduler: RTL
======================

SR_LOAD_SCHEDULER -- requirements
Module: sr_load_scheduler

Interface
REQ-001 The block SHALL provide parameter SIZESRSTAT, default 88: static shift register length in bits.
REQ-002 The block SHALL provide parameter SIZESRDYN, default 16: dynamic shift register length in bits.
REQ-003 The block SHALL provide parameter N_SETUP, default 8: cycles in SETUP, range 1..255.
REQ-004 The block SHALL provide parameter N_GAP, default 8: cycles in GAP, range 1..255.
REQ-005 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-006 The block SHALL provide the following ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous active-high reset.
- stat_req  in  1  static load request; level, held until stat_ack.
- stat_data  in  SIZESRSTAT  static word; sampled in the cycle stat_ack=1.
- dyn_req  in  1  dynamic load request; level, held until dyn_ack.
- dyn_data  in  SIZESRDYN  dynamic word; sampled in the cycle dyn_ack=1.
- stat_ack  out  1  one-cycle grant/capture pulse for the static request.
- dyn_ack  out  1  one-cycle grant/capture pulse for the dynamic request.
- sel_stat  out  1  static register selected.
- sel_dyn  out  1  dynamic register selected.
- sen  out  1  shift enable to the selected register.
- sdata  out  1  serial data, MSB first.
- latch  out  1  one-cycle load strobe to the selected register.
- done  out  1  one-cycle transfer-complete pulse.
- busy  out  1  high in any state other than IDLE.

Function
REQ-007 The state machine SHALL have the states IDLE, SETUP, SHIFT, LATCH and GAP; all outputs SHALL be registered.
REQ-008 In IDLE with at least one request pending, the block SHALL grant exactly one requester, pulse its ack for one cycle, capture its data into an internal shift register, record the target (static/dynamic), and enter SETUP on the next edge.
REQ-009 Arbitration SHALL be round-robin on a last_grant flag:
- Both requests pending: grant the type not granted last.
- Single pending request: granted regardless of last_grant.
- Reset value of last_grant = static, so the first simultaneous request grants dynamic.
REQ-010 SETUP SHALL last exactly N_SETUP cycles with the target sel high, sen=0, then go to SHIFT.
REQ-011 SHIFT SHALL last exactly L cycles, where L = SIZESRSTAT or SIZESRDYN per target, with sen=1 and sel high.
- In SHIFT cycle k (k=0..L-1), sdata SHALL equal captured_data[L-1-k].
REQ-012 LATCH SHALL last one cycle: latch=1, sen=0, sdata=0, sel still high.
REQ-013 GAP SHALL last exactly N_GAP cycles with sel_stat=sel_dyn=sen=latch=0.
- done SHALL pulse in the first GAP cycle only.
- Exit is to IDLE.
REQ-014 sel_stat and sel_dyn SHALL never be high simultaneously.
REQ-015 sdata SHALL be 0 outside SHIFT.
REQ-016 Requests SHALL be ignored outside IDLE and SHALL remain pending; no ack SHALL be issued outside IDLE.
REQ-017 The minimum spacing between consecutive acks SHALL be N_SETUP+L+1+N_GAP+1 cycles.
REQ-018 Data widths:
- Counters SHALL be sized to hold max(SIZESRSTAT, N_SETUP, N_GAP) without wrap; the 88-bit default needs 7 bits.
- Dynamic data SHALL occupy the low SIZESRDYN bits of the internal shift register.
REQ-019 A request deasserted before its ack (protocol violation) SHALL not be granted; no partial transfer SHALL occur.

Reset
REQ-020 Assertion of RST at any time SHALL immediately force:
- State IDLE, last_grant=static.
- All counters 0.
- All outputs 0: stat_ack, dyn_ack, sel_stat, sel_dyn, sen, sdata, latch, done, busy.
REQ-021 A transfer interrupted by reset SHALL be discarded with no latch or done pulse; after RST deasserts, pending requests SHALL be re-arbitrated from IDLE.

Verification
REQ-022 Dynamic request, dyn_data=16'h8001 -> the bench SHALL check all of the following:
- dyn_ack for 1 cycle.
- 8 SETUP cycles with sel_dyn=1.
- 16 sen cycles with sdata = 1,0×14,1.
- latch in the next cycle, then done.
- busy low again after 8 GAP cycles.
REQ-023 Static request, stat_data={8'hA5, 80'h0} -> first 8 sdata bits = 1,0,1,0,0,1,0,1, then 80 zeros; sen high for exactly 88 cycles; sel_dyn stays 0.
REQ-024 stat_req and dyn_req asserted in the same cycle after reset, both held -> dyn granted first, stat granted second; acks spaced 34 cycles apart (8+16+1+8+1).
REQ-025 RST pulsed for 1 cycle at SHIFT cycle 5 of a dynamic transfer -> all outputs 0 in the same cycle; no latch and no done; with dyn_req still high, a new dyn_ack appears in the first cycle after RST deasserts.
REQ-026 stat_req raised during a dynamic transfer's GAP -> no stat_ack until IDLE; stat_ack occurs in the IDLE cycle following GAP.

Source files
------------

// File: rtl/sr_load_scheduler.sv
// Round-robin loader for a static and a dynamic serial shift-register chain:
// grant in IDLE, then SETUP, SHIFT (MSB first), LATCH and GAP.
module sr_load_scheduler #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int N_SETUP    = 8,
    parameter int N_GAP      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  stat_req,
    input  logic [SIZESRSTAT-1:0] stat_data,
    input  logic                  dyn_req,
    input  logic [SIZESRDYN-1:0]  dyn_data,
    output logic                  stat_ack,
    output logic                  dyn_ack,
    output logic                  sel_stat,
    output logic                  sel_dyn,
    output logic                  sen,
    output logic                  sdata,
    output logic                  latch,
    output logic                  done,
    output logic                  busy
);
    localparam int MAX_A = (SIZESRSTAT > N_SETUP) ? SIZESRSTAT : N_SETUP;
    localparam int MAX_V = (MAX_A > N_GAP) ? MAX_A : N_GAP;
    localparam int CW    = $clog2(MAX_V + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                state_r;
    logic [CW-1:0]         cnt_r;
    logic [SIZESRSTAT-1:0] sr_r;
    logic                  tgt_stat_r;
    logic                  last_grant_dyn_r;
    logic                  grant_stat_s;
    logic                  grant_dyn_s;
    logic                  arb_en_s;
    logic                  msb_s;
    logic [CW-1:0]         len_m1_s;

    // Round-robin pick: with both pending, the type not granted last wins
    always_comb begin
        grant_stat_s = 1'b0;
        grant_dyn_s  = 1'b0;
        if (stat_req && (!dyn_req || last_grant_dyn_r)) begin
            grant_stat_s = 1'b1;
        end else if (dyn_req) begin
            grant_dyn_s = 1'b1;
        end else begin
            grant_stat_s = 1'b0;
            grant_dyn_s  = 1'b0;
        end
    end

    // Arbitration window, shift length and serial tap for the current target
    always_comb begin
        arb_en_s = 1'b0;
        if ((state_r == ST_IDLE) && !stat_ack && !dyn_ack) begin
            arb_en_s = 1'b1;
        end else if ((state_r == ST_GAP) && (cnt_r == CW'(N_GAP - 1))) begin
            arb_en_s = 1'b1;
        end else begin
            arb_en_s = 1'b0;
        end
        if (tgt_stat_r) begin
            len_m1_s = CW'(SIZESRSTAT - 1);
            msb_s    = sr_r[SIZESRSTAT-1];
        end else begin
            len_m1_s = CW'(SIZESRDYN - 1);
            msb_s    = sr_r[SIZESRDYN-1];
        end
    end

    // Sequencer: state, counter, shift register and every registered output
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r          <= ST_IDLE;
            cnt_r            <= {CW{1'b0}};
            sr_r             <= {SIZESRSTAT{1'b0}};
            tgt_stat_r       <= 1'b0;
            last_grant_dyn_r <= 1'b0;
            stat_ack         <= 1'b0;
            dyn_ack          <= 1'b0;
            sel_stat         <= 1'b0;
            sel_dyn          <= 1'b0;
            sen              <= 1'b0;
            sdata            <= 1'b0;
            latch            <= 1'b0;
            done             <= 1'b0;
            busy             <= 1'b0;
        end else begin
            stat_ack <= 1'b0;
            dyn_ack  <= 1'b0;
            latch    <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (stat_ack || dyn_ack) begin
                        sr_r     <= stat_ack ? stat_data : SIZESRSTAT'(dyn_data);
                        sel_stat <= tgt_stat_r;
                        sel_dyn  <= ~tgt_stat_r;
                        busy     <= 1'b1;
                        cnt_r    <= {CW{1'b0}};
                        state_r  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == CW'(N_SETUP - 1)) begin
                        cnt_r   <= {CW{1'b0}};
                        sen     <= 1'b1;
                        sdata   <= msb_s;
                        sr_r    <= {sr_r[SIZESRSTAT-2:0], 1'b0};
                        state_r <= ST_SHIFT;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == len_m1_s) begin
                        cnt_r   <= {CW{1'b0}};
                        sen     <= 1'b0;
                        sdata   <= 1'b0;
                        latch   <= 1'b1;
                        state_r <= ST_LATCH;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                        sdata <= msb_s;
                        sr_r  <= {sr_r[SIZESRSTAT-2:0], 1'b0};
                    end
                end
                ST_LATCH: begin
                    sel_stat <= 1'b0;
                    sel_dyn  <= 1'b0;
                    done     <= 1'b1;
                    cnt_r    <= {CW{1'b0}};
                    state_r  <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt_r == CW'(N_GAP - 1)) begin
                        cnt_r   <= {CW{1'b0}};
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    cnt_r    <= {CW{1'b0}};
                    sel_stat <= 1'b0;
                    sel_dyn  <= 1'b0;
                    sen      <= 1'b0;
                    sdata    <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
            // A new grant is issued only from IDLE or as the last GAP cycle ends
            if (arb_en_s) begin
                stat_ack <= grant_stat_s;
                dyn_ack  <= grant_dyn_s;
                if (grant_stat_s || grant_dyn_s) begin
                    tgt_stat_r       <= grant_stat_s;
                    last_grant_dyn_r <= grant_dyn_s;
                end
            end
        end
    end
endmodule
